mips32_rtype_sequencer: RTL and testbench

//  Multi-cycle control unit in front of the mips32 R-type register-file/ALU datapath.

---
 rtl/mips32_ctrl_pkg.sv | 65 ++++++
 rtl/mips32_instr_fifo.sv | 68 ++++++
 rtl/mips32_rtype_sequencer.sv | 153 +++++++++++++++
 tb/tb_mips32_rtype_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_ctrl_pkg.sv
// Shared definitions for the mips32 R-type sequencer: opcode/funct constants,
// ALU control encoding, FSM states and the instruction decoder.
package mips32_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;

    typedef struct packed {
        logic      legal;
        alu_ctrl_e ctrl;
        logic      is_shift;
        logic      ovf_traps;   // signed ops whose overflow suppresses the write
    } decode_t;

    function automatic decode_t decode_instr(input logic [5:0] op, input logic [5:0] funct);
        decode_t d;
        d = '{legal: 1'b1, ctrl: ALU_ADD, is_shift: 1'b0, ovf_traps: 1'b0};
        case (funct)
            F_ADD:   begin d.ctrl = ALU_ADD; d.ovf_traps = 1'b1; end
            F_ADDU:  d.ctrl = ALU_ADDU;
            F_SUB:   begin d.ctrl = ALU_SUB; d.ovf_traps = 1'b1; end
            F_SUBU:  d.ctrl = ALU_SUBU;
            F_AND:   d.ctrl = ALU_AND;
            F_OR:    d.ctrl = ALU_OR;
            F_NOR:   d.ctrl = ALU_NOR;
            F_SLTU:  d.ctrl = ALU_SLTU;
            F_SLL:   begin d.ctrl = ALU_SLL; d.is_shift = 1'b1; end
            F_SRL:   begin d.ctrl = ALU_SRL; d.is_shift = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        if (op != OP_RTYPE) d.legal = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/mips32_instr_fifo.sv
// Instruction buffer: DEPTH x WIDTH circular FIFO with registered full/empty flags.
module mips32_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;    // power-of-two depth wraps naturally
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage has no reset; entries are only read after being written, and the flags gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/mips32_rtype_sequencer.sv
// Multi-cycle R-type control unit: buffers instructions, decodes them and sequences
// RF read, ALU execute and RF write-back, with illegal/overflow reporting.
module mips32_rtype_sequencer
    import mips32_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr_data,
    output logic             instr_ready,
    output logic [4:0]       rf_rd_addr_a,
    output logic [4:0]       rf_rd_addr_b,
    input  logic [31:0]      rf_rd_data_a,
    input  logic [31:0]      rf_rd_data_b,
    output logic [3:0]       alu_ctrl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_result,
    input  logic             alu_overflow,
    output logic             rf_wr_en,
    output logic [4:0]       rf_wr_addr,
    output logic [31:0]      rf_wr_data,
    output logic             busy,
    output logic             illegal,
    output logic             ovf_trap,
    output logic [CNT_W-1:0] retired_count
);
    state_e           state_q, state_d;
    logic [31:0]      head;
    logic             fifo_full, fifo_empty, push, pop;
    logic             work_avail, trap;
    decode_t          dec;
    logic [4:0]       rd_q, rd_d, shamt_q, shamt_d;
    alu_ctrl_e        ctrl_q, ctrl_d;
    logic             is_shift_q, is_shift_d, traps_q, traps_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign instr_ready   = !fifo_full;
    assign push          = instr_valid && !fifo_full;
    assign busy          = (state_q != IDLE) || !fifo_empty;
    assign retired_count = count_q;
    assign dec           = decode_instr(head[31:26], head[5:0]);
    // A word being pushed this cycle counts, so an empty FIFO reaches DECODE one cycle after the push.
    assign work_avail    = !fifo_empty || push;

    mips32_instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (instr_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        shamt_d      = shamt_q;
        ctrl_d       = ctrl_q;
        is_shift_d   = is_shift_q;
        traps_d      = traps_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        count_d      = count_q;
        pop          = 1'b0;
        trap         = 1'b0;
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        alu_ctrl     = '0;
        alu_a        = '0;
        alu_b        = '0;
        alu_shamt    = '0;
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        illegal      = 1'b0;
        ovf_trap     = 1'b0;

        case (state_q)
            IDLE: if (work_avail) state_d = DECODE;
            DECODE: begin
                pop          = 1'b1;
                rf_rd_addr_a = head[25:21];
                rf_rd_addr_b = head[20:16];
                if (!dec.legal) begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_d       = head[15:11];
                    shamt_d    = head[10:6];
                    ctrl_d     = dec.ctrl;
                    is_shift_d = dec.is_shift;
                    traps_d    = dec.ovf_traps;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                alu_ctrl  = ctrl_q;
                alu_a     = is_shift_q ? rf_rd_data_b : rf_rd_data_a;
                alu_b     = is_shift_q ? 32'd0 : rf_rd_data_b;
                alu_shamt = is_shift_q ? shamt_q : 5'd0;
                result_d  = alu_result;
                ovf_d     = alu_overflow;
                state_d   = WB;
            end
            WB: begin
                trap     = traps_q && ovf_q;
                ovf_trap = trap;
                if (!trap && rd_q != 5'd0) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = rd_q;
                    rf_wr_data = result_q;
                end
                if (!trap) count_d = count_q + 1'b1;
                state_d = work_avail ? DECODE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            shamt_q    <= '0;
            ctrl_q     <= ALU_ADD;
            is_shift_q <= 1'b0;
            traps_q    <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            shamt_q    <= shamt_d;
            ctrl_q     <= ctrl_d;
            is_shift_q <= is_shift_d;
            traps_q    <= traps_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_mips32_rtype_sequencer.sv
// Directed bench for mips32_rtype_sequencer with RF/ALU models and a write-back scoreboard.
module tb_mips32_rtype_sequencer;

    typedef enum logic [1:0] {EV_WRITE, EV_SILENT, EV_TRAP, EV_ILLEGAL} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [4:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic        clk, rst_n, instr_valid, instr_ready;
    logic [31:0] instr_data;
    logic [4:0]  rf_rd_addr_a, rf_rd_addr_b, alu_shamt, rf_wr_addr;
    logic [31:0] rf_rd_data_a, rf_rd_data_b, alu_a, alu_b, alu_result, rf_wr_data;
    logic [3:0]  alu_ctrl;
    logic        alu_overflow, rf_wr_en, busy, illegal, ovf_trap;
    logic [15:0] retired_count;

    int tests = 0;
    int fails = 0;

    mips32_rtype_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_ready   (instr_ready),
        .rf_rd_addr_a  (rf_rd_addr_a),
        .rf_rd_addr_b  (rf_rd_addr_b),
        .rf_rd_data_a  (rf_rd_data_a),
        .rf_rd_data_b  (rf_rd_data_b),
        .alu_ctrl      (alu_ctrl),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_shamt     (alu_shamt),
        .alu_result    (alu_result),
        .alu_overflow  (alu_overflow),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .busy          (busy),
        .illegal       (illegal),
        .ovf_trap      (ovf_trap),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: read data appears one cycle after the address.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
    end

    // Combinational ALU model.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'd0, 4'd1: begin
                alu_result = alu_a + alu_b;
                if (alu_ctrl == 4'd0)
                    alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd2, 4'd3: begin
                alu_result = alu_a - alu_b;
                if (alu_ctrl == 4'd2)
                    alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd4: alu_result = alu_a & alu_b;
            4'd5: alu_result = alu_a | alu_b;
            4'd6: alu_result = ~(alu_a | alu_b);
            4'd7: alu_result = {31'd0, alu_a < alu_b};
            4'd8: alu_result = alu_a << alu_shamt;
            4'd9: alu_result = alu_a >> alu_shamt;
            default: alu_result = '0;
        endcase
    end

    // Monitor: records every observable retirement-side event in order.
    ev_t         obs_mem [256];
    int          obs_wr = 0;
    int          obs_rd = 0;
    logic [15:0] prev_cnt = '0;
    logic        prev_wr = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (retired_count != prev_cnt && !prev_wr) begin
                obs_mem[obs_wr % 256] = '{EV_SILENT, 5'd0, 32'd0};
                obs_wr = obs_wr + 1;
            end
            if (rf_wr_en) begin
                obs_mem[obs_wr % 256] = '{EV_WRITE, rf_wr_addr, rf_wr_data};
                obs_wr = obs_wr + 1;
            end else if (ovf_trap) begin
                obs_mem[obs_wr % 256] = '{EV_TRAP, 5'd0, 32'd0};
                obs_wr = obs_wr + 1;
            end else if (illegal) begin
                obs_mem[obs_wr % 256] = '{EV_ILLEGAL, 5'd0, 32'd0};
                obs_wr = obs_wr + 1;
            end
        end
        prev_cnt = retired_count;
        prev_wr  = rf_wr_en;
    end

    ev_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    task automatic expect_ev(input ev_kind_e kind, input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back('{kind, addr, data});
    endtask

    task automatic compare_events();
        ev_t o, e;
        while (obs_rd < obs_wr) begin
            o = obs_mem[obs_rd % 256];
            obs_rd++;
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_kind", 32'(o.kind), 32'(e.kind));
                check("sb_addr", 32'(o.addr), 32'(e.addr));
                check("sb_data", o.data, e.data);
            end
        end
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("drain_timeout", 32'(busy), 32'd0);
        @(negedge clk);
        @(posedge clk);
        compare_events();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   32'(instr_ready), 32'd1);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_wr_en"},   32'(rf_wr_en), 32'd0);
        check({tag, "_wr_data"}, rf_wr_data, 32'd0);
        check({tag, "_alu_a"},   alu_a, 32'd0);
        check({tag, "_alu_ctl"}, 32'(alu_ctrl), 32'd0);
        check({tag, "_rd_a"},    32'(rf_rd_addr_a), 32'd0);
        check({tag, "_flags"},   32'({illegal, ovf_trap}), 32'd0);
        check({tag, "_count"},   32'(retired_count), 32'd0);
    endtask

    // add $18,$16,$17 into an empty FIFO: write at cycle 3, count 1 afterwards.
    task automatic run_add_test(input string tag);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 32'h02119020;
        expect_ev(EV_WRITE, 5'd18, 32'd8);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check({tag, "_c2_wr_en"}, 32'(rf_wr_en), 32'd0);
        @(negedge clk);
        check({tag, "_c3_wr_en"}, 32'(rf_wr_en), 32'd1);
        check({tag, "_c3_addr"},  32'(rf_wr_addr), 32'd18);
        check({tag, "_c3_data"},  rf_wr_data, 32'd8);
        @(negedge clk);
        check({tag, "_count"},    32'(retired_count), 32'd1);
        drain(50);
    endtask

    initial begin
        logic [15:0] cnt0;
        int          cnt, k, t;
        logic        exp_rdy, model_pop, saw_low;

        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h100;
        rf[16] = 32'd5;
        rf[17] = 32'd3;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Test 1
        run_add_test("t1");

        // Test 2: sll, sltu, nor back-to-back
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = enc(6'h00, 5'd0, 5'd17, 5'd19, 5'd1, 6'h00);
        expect_ev(EV_WRITE, 5'd19, 32'd6);
        @(negedge clk);
        instr_data  = enc(6'h00, 5'd16, 5'd17, 5'd3, 5'd0, 6'h2B);
        expect_ev(EV_WRITE, 5'd3, 32'd0);
        @(negedge clk);
        instr_data  = enc(6'h00, 5'd16, 5'd17, 5'd1, 5'd0, 6'h27);
        expect_ev(EV_WRITE, 5'd1, 32'hFFFF_FFF8);
        @(negedge clk);
        instr_valid = 1'b0;
        check("t2_c3_wr_en", 32'(rf_wr_en), 32'd1);
        check("t2_c3_data",  rf_wr_data, 32'd6);
        repeat (3) @(negedge clk);
        check("t2_c6_wr_en", 32'(rf_wr_en), 32'd1);
        check("t2_c6_addr",  32'(rf_wr_addr), 32'd3);
        repeat (3) @(negedge clk);
        check("t2_c9_wr_en", 32'(rf_wr_en), 32'd1);
        check("t2_c9_data",  rf_wr_data, 32'hFFFF_FFF8);
        drain(50);

        // Test 3: sub overflow traps, subu with the same operands writes
        rf[16] = 32'h7FFF_FFFF;
        rf[17] = 32'hFFFF_FFFF;
        cnt0   = retired_count;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = enc(6'h00, 5'd16, 5'd17, 5'd4, 5'd0, 6'h22);
        expect_ev(EV_TRAP, 5'd0, 32'd0);
        @(negedge clk);
        instr_data  = enc(6'h00, 5'd16, 5'd17, 5'd5, 5'd0, 6'h23);
        expect_ev(EV_WRITE, 5'd5, 32'h8000_0000);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("t3_trap",       32'(ovf_trap), 32'd1);
        check("t3_trap_wr_en", 32'(rf_wr_en), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_subu_data",  rf_wr_data, 32'h8000_0000);
        drain(50);
        check("t3_count", 32'(retired_count), 32'(cnt0 + 16'd1));
        rf[16] = 32'd5;
        rf[17] = 32'd3;

        // Test 4: lw is illegal, and with rd=0 retires silently
        cnt0 = retired_count;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 32'h8E08_0000;
        expect_ev(EV_ILLEGAL, 5'd0, 32'd0);
        @(negedge clk);
        check("t4_illegal", 32'(illegal), 32'd1);
        instr_data  = 32'h0211_0024;
        expect_ev(EV_SILENT, 5'd0, 32'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        check("t4_illegal_once", 32'(illegal), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_and_wr_en", 32'(rf_wr_en), 32'd0);
        drain(50);
        check("t4_count", 32'(retired_count), 32'(cnt0 + 16'd1));

        // Test 5: 8 adds with instr_valid held; FIFO fill level modelled from push/pop timing
        @(negedge clk);
        cnt = 0; k = 0; t = 0; saw_low = 1'b0;
        instr_valid = 1'b1;
        while (k < 8 && t < 200) begin
            instr_data = enc(6'h00, 5'(k + 1), 5'(k + 2), 5'(20 + k), 5'd0, 6'h20);
            exp_rdy    = (cnt < 4);
            check("t5_ready", 32'(instr_ready), 32'(exp_rdy));
            if (!exp_rdy) saw_low = 1'b1;
            model_pop = (t >= 1) && (((t - 1) % 3) == 0) && (cnt > 0);
            if (exp_rdy) cnt++;
            if (model_pop) cnt--;
            if (instr_ready) begin
                expect_ev(EV_WRITE, 5'(20 + k), 32'h100 * 32'(2 * k + 3));
                k++;
            end
            t++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("t5_all_pushed", 32'(k), 32'd8);
        check("t5_saw_full",   32'(saw_low), 32'd1);
        drain(200);

        // Test 6: reset during EXEC aborts the instruction
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 32'h02119020;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (3) @(negedge clk);
        check("t6_no_write", 32'(rf_wr_en), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        obs_rd = obs_wr;
        @(negedge clk);
        check_reset_outputs("t6_post");
        run_add_test("t6_rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
